// File: rtl/alu_decoder_md.sv
// ALU control decode for the multicycle MIPS datapath, with an iterative
// multiply/divide engine that owns the architectural HI/LO registers.
`timescale 1ns/1ps

module alu_decoder_md #(
   parameter int WIDTH = 32,
   parameter bit MD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic             start,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [2:0]       alucontrol,
   output logic [WIDTH-1:0] hilo_out,
   output logic             illegal,
   output logic             busy,
   output logic             stall,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for an MD start; MTHI/MTLO write here
   // MUL   | shift-add multiply, one multiplier bit per cycle
   // DIV   | restoring divide, one quotient bit per cycle
   // DONE  | HI/LO hold the new result; done pulses for this cycle
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam int       CW  = $clog2(WIDTH);
   localparam logic     MDE = MD_EN;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   state_t             state;
   logic [WIDTH-1:0]   hi, lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvd_raw;
   logic               neg_q, neg_r, divz;
   logic [CW-1:0]      count;

   logic rtype, is_r_funct, is_md_funct, is_muldiv, signed_op, last;
   logic [WIDTH-1:0]   abs_a, abs_b;

   assign rtype       = (aluop == 2'b10);
   assign is_r_funct  = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
   assign is_muldiv   = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   assign is_md_funct = is_muldiv || (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
   assign illegal     = rtype & ~is_r_funct & ~(MDE & is_md_funct);
   assign stall       = busy & rtype & is_md_funct;

   always_comb begin
      alucontrol = 3'b000;
      case (aluop)
         2'b00: alucontrol = 3'b010;
         2'b01: alucontrol = 3'b110;
         2'b11: alucontrol = 3'b001;
         default: begin
            case (funct)
               F_ADD:   alucontrol = 3'b010;
               F_SUB:   alucontrol = 3'b110;
               F_AND:   alucontrol = 3'b000;
               F_OR:    alucontrol = 3'b001;
               F_SLT:   alucontrol = 3'b111;
               default: alucontrol = 3'b000;
            endcase
         end
      endcase
   end

   always_comb begin
      hilo_out = '0;
      if (MDE && rtype && funct == F_MFHI)
         hilo_out = hi;
      else if (MDE && rtype && funct == F_MFLO)
         hilo_out = lo;
   end

   // Signed forms have funct[0]=0; the engine works on magnitudes.
   assign signed_op = ~funct[0];
   assign abs_a     = (signed_op && srca[WIDTH-1]) ? -srca : srca;
   assign abs_b     = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;
   assign last      = (count == CW'(WIDTH-1));

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, mul_res;
   logic [WIDTH:0]     div_shift, rem_next;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   quo_next, q_res, r_res;

   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, prod[WIDTH-1:1]};
      mul_res   = neg_q ? -mul_next : mul_next;
      div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, mcand};
      div_ok    = ~div_diff[WIDTH+1];
      rem_next  = div_ok ? div_diff[WIDTH:0] : div_shift;
      quo_next  = {quo[WIDTH-2:0], div_ok};
      // Divide by zero bypasses the sign fix-up: LO all ones, HI the raw dividend.
      q_res     = divz ? {WIDTH{1'b1}} : (neg_q ? -quo_next : quo_next);
      r_res     = divz ? dvd_raw : (neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         hi      <= '0;
         lo      <= '0;
         prod    <= '0;
         mcand   <= '0;
         rem     <= '0;
         quo     <= '0;
         dvd_raw <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         divz    <= 1'b0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && rtype && MDE) begin
                  if (is_muldiv) begin
                     count   <= '0;
                     busy    <= 1'b1;
                     neg_q   <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                     neg_r   <= signed_op & srca[WIDTH-1];
                     divz    <= (srcb == '0);
                     dvd_raw <= srca;
                     if (funct[1]) begin
                        state <= S_DIV;
                        rem   <= '0;
                        quo   <= abs_a;
                        mcand <= abs_b;
                     end else begin
                        state <= S_MUL;
                        prod  <= {{WIDTH{1'b0}}, abs_b};
                        mcand <= abs_a;
                     end
                  end else if (funct == F_MTHI) begin
                     hi <= srca;
                  end else if (funct == F_MTLO) begin
                     lo <= srca;
                  end
               end
            end
            S_MUL: begin
               prod  <= mul_next;
               count <= count + CW'(1);
               if (last) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= mul_res[2*WIDTH-1:WIDTH];
                  lo    <= mul_res[WIDTH-1:0];
               end
            end
            S_DIV: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + CW'(1);
               if (last) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= r_res;
                  lo    <= q_res;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
